control_unit: RTL and testbench

Multicycle control FSM for the CHARIS processor. It sits directly upstream of `datapath`, consuming its `Instr` and `ALU_Out` outputs and driving every datapath control input. Instructions are sequenced through fetch, decode, execute, memory and write-back states. It also flags illegal opcodes and maintains a retired-instruction counter.

---
 rtl/control_pkg.sv | 68 ++++++
 rtl/control_decode.sv | 68 ++++++
 rtl/control_unit.sv | 124 ++++++++++++
 tb/tb_control_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared encodings for the CHARIS multicycle control unit: opcodes, ALU
// functions, FSM states and the decoded per-class control bundle.
package control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LW    = 6'b000011;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_NOP
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LW,
    CLS_SW,
    CLS_B,
    CLS_BEQ,
    CLS_BNE,
    CLS_ILLEGAL
  } instr_class_t;

  typedef struct packed {
    instr_class_t cls;
    logic [3:0]   alu_func;
    logic         alu_bin_sel;
    logic         rf_b_sel;
    logic         rf_wrdata_sel;
  } ctrl_t;

  // Illegal/unknown opcodes drive every select low so the datapath idles.
  localparam ctrl_t CTRL_NONE = '{
    cls:           CLS_ILLEGAL,
    alu_func:      ALU_ADD,
    alu_bin_sel:   1'b0,
    rf_b_sel:      1'b0,
    rf_wrdata_sel: 1'b0
  };

  localparam ctrl_t CTRL_RESET = '{
    cls:           CLS_ALU,
    alu_func:      ALU_ADD,
    alu_bin_sel:   1'b0,
    rf_b_sel:      1'b0,
    rf_wrdata_sel: 1'b0
  };

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decoder: maps an instruction word to its class,
// datapath selects, ALU function and an illegal-opcode flag.
module control_decode
  import control_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal
);

  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:4];

  always_comb begin
    ctrl = CTRL_NONE;
    case (instr[31:26])
      OP_RTYPE: begin
        ctrl.cls      = CLS_ALU;
        ctrl.alu_func = instr[3:0];
      end
      OP_ADDI: begin
        ctrl.cls         = CLS_ALU;
        ctrl.alu_func    = ALU_ADD;
        ctrl.alu_bin_sel = 1'b1;
      end
      OP_ANDI: begin
        ctrl.cls         = CLS_ALU;
        ctrl.alu_func    = ALU_AND;
        ctrl.alu_bin_sel = 1'b1;
      end
      OP_ORI: begin
        ctrl.cls         = CLS_ALU;
        ctrl.alu_func    = ALU_OR;
        ctrl.alu_bin_sel = 1'b1;
      end
      OP_LW: begin
        ctrl.cls           = CLS_LW;
        ctrl.alu_func      = ALU_ADD;
        ctrl.alu_bin_sel   = 1'b1;
        ctrl.rf_wrdata_sel = 1'b1;
      end
      OP_SW: begin
        ctrl.cls         = CLS_SW;
        ctrl.alu_func    = ALU_ADD;
        ctrl.alu_bin_sel = 1'b1;
        ctrl.rf_b_sel    = 1'b1;
      end
      OP_B: begin
        ctrl.cls = CLS_B;
      end
      // Conditional branches compare rs against rd via subtraction.
      OP_BEQ: begin
        ctrl.cls      = CLS_BEQ;
        ctrl.alu_func = ALU_SUB;
        ctrl.rf_b_sel = 1'b1;
      end
      OP_BNE: begin
        ctrl.cls      = CLS_BNE;
        ctrl.alu_func = ALU_SUB;
        ctrl.rf_b_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign illegal = (ctrl.cls == CLS_ILLEGAL);

endmodule

// File: rtl/control_unit.sv
// Multicycle control FSM for CHARIS: sequences each instruction through
// fetch/decode/execute/memory/write-back and counts retired instructions.
module control_unit
  import control_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Instr,
  input  logic [31:0] ALU_Out,
  output logic        PC_Sel,
  output logic        PC_LdEn,
  output logic        RF_WrEn,
  output logic        RF_WrData_sel,
  output logic        RF_B_sel,
  output logic        ALU_Bin_sel,
  output logic [3:0]  ALU_func,
  output logic        Mem_WrEn,
  output logic        Illegal_Instr,
  output logic [31:0] Instr_Retired
);

  state_t      state_q, state_d;
  ctrl_t       ctrl_q, ctrl_d;
  logic [31:0] instr_retired_q, instr_retired_d;

  ctrl_t dec_ctrl;
  logic  dec_illegal;
  ctrl_t ctrl_active;

  logic pc_sel, pc_ld_en, rf_wr_en, mem_wr_en, illegal_pulse;

  control_decode u_decode (
    .instr   (Instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= S_FETCH;
      ctrl_q          <= CTRL_RESET;
      instr_retired_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      ctrl_q          <= ctrl_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  // The decoded bundle is captured in DECODE so selects stay fixed until the PC load.
  assign ctrl_d      = (state_q == S_DECODE) ? dec_ctrl : ctrl_q;
  assign ctrl_active = (state_q == S_FETCH || state_q == S_DECODE) ? dec_ctrl : ctrl_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_NOP;
        end else begin
          case (dec_ctrl.cls)
            CLS_ALU:                  state_d = S_EXEC;
            CLS_LW, CLS_SW:           state_d = S_MEM_ADDR;
            CLS_B, CLS_BEQ, CLS_BNE:  state_d = S_BRANCH;
            default:                  state_d = S_NOP;
          endcase
        end
      end
      S_EXEC:     state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (ctrl_q.cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_MEM;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_sel        = 1'b0;
    pc_ld_en      = 1'b0;
    rf_wr_en      = 1'b0;
    mem_wr_en     = 1'b0;
    illegal_pulse = 1'b0;
    case (state_q)
      S_WB_ALU, S_WB_MEM: begin
        rf_wr_en = 1'b1;
        pc_ld_en = 1'b1;
      end
      S_MEM_WR: begin
        mem_wr_en = 1'b1;
        pc_ld_en  = 1'b1;
      end
      // Branch resolution is Mealy on ALU_Out so the taken decision lands this cycle.
      S_BRANCH: begin
        pc_ld_en = 1'b1;
        case (ctrl_q.cls)
          CLS_B:   pc_sel = 1'b1;
          CLS_BEQ: pc_sel = (ALU_Out == 32'd0);
          CLS_BNE: pc_sel = (ALU_Out != 32'd0);
          default: pc_sel = 1'b0;
        endcase
      end
      S_NOP: begin
        pc_ld_en      = 1'b1;
        illegal_pulse = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces every output low immediately, without waiting for a clock.
  assign PC_Sel        = pc_sel & ~Reset;
  assign PC_LdEn       = pc_ld_en & ~Reset;
  assign RF_WrEn       = rf_wr_en & ~Reset;
  assign Mem_WrEn      = mem_wr_en & ~Reset;
  assign Illegal_Instr = illegal_pulse & ~Reset;
  assign RF_WrData_sel = ctrl_active.rf_wrdata_sel & ~Reset;
  assign RF_B_sel      = ctrl_active.rf_b_sel & ~Reset;
  assign ALU_Bin_sel   = ctrl_active.alu_bin_sel & ~Reset;
  assign ALU_func      = Reset ? 4'b0000 : ctrl_active.alu_func;

  assign instr_retired_d = PC_LdEn ? instr_retired_q + 32'd1 : instr_retired_q;
  assign Instr_Retired   = instr_retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: per-instruction expectations come from
// an opcode-level behavioural model of cycle counts and per-class controls.
module tb_control_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] Instr;
  logic [31:0] ALU_Out;
  logic        PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel;
  logic [3:0]  ALU_func;
  logic        Mem_WrEn, Illegal_Instr;
  logic [31:0] Instr_Retired;

  int          test_count = 0;
  int          fail_count = 0;
  logic [31:0] model_retired = 32'd0;

  control_unit dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .Instr         (Instr),
    .ALU_Out       (ALU_Out),
    .PC_Sel        (PC_Sel),
    .PC_LdEn       (PC_LdEn),
    .RF_WrEn       (RF_WrEn),
    .RF_WrData_sel (RF_WrData_sel),
    .RF_B_sel      (RF_B_sel),
    .ALU_Bin_sel   (ALU_Bin_sel),
    .ALU_func      (ALU_func),
    .Mem_WrEn      (Mem_WrEn),
    .Illegal_Instr (Illegal_Instr),
    .Instr_Retired (Instr_Retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    int         cpi;
    logic [3:0] func;
    logic       wd_sel;
    logic       b_sel;
    logic       bin_sel;
    logic       rf_wr;
    logic       mem_wr;
    logic       ill;
    logic       pc_sel;
  } expect_t;

  localparam logic [5:0] LEGAL_OPS [9] = '{6'b100000, 6'b110000, 6'b110010, 6'b110011,
                                          6'b000011, 6'b011111, 6'b111111, 6'b010000,
                                          6'b010001};

  function automatic bit is_legal(input logic [5:0] op);
    for (int i = 0; i < 9; i++)
      if (LEGAL_OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Behavioural model: what one instruction should look like from outside.
  function automatic expect_t predict(input logic [31:0] instr, input logic [31:0] alu);
    expect_t e;
    e = '{cpi: 3, func: 4'b0000, wd_sel: 1'b0, b_sel: 1'b0, bin_sel: 1'b0,
          rf_wr: 1'b0, mem_wr: 1'b0, ill: 1'b0, pc_sel: 1'b0};
    case (instr[31:26])
      6'b100000: begin e.cpi = 4; e.func = instr[3:0]; e.rf_wr = 1'b1; end
      6'b110000: begin e.cpi = 4; e.func = 4'b0000; e.bin_sel = 1'b1; e.rf_wr = 1'b1; end
      6'b110010: begin e.cpi = 4; e.func = 4'b0010; e.bin_sel = 1'b1; e.rf_wr = 1'b1; end
      6'b110011: begin e.cpi = 4; e.func = 4'b0011; e.bin_sel = 1'b1; e.rf_wr = 1'b1; end
      6'b000011: begin e.cpi = 5; e.bin_sel = 1'b1; e.wd_sel = 1'b1; e.rf_wr = 1'b1; end
      6'b011111: begin e.cpi = 4; e.bin_sel = 1'b1; e.b_sel = 1'b1; e.mem_wr = 1'b1; end
      6'b111111: begin e.cpi = 3; e.pc_sel = 1'b1; end
      6'b010000: begin e.cpi = 3; e.func = 4'b0001; e.b_sel = 1'b1; e.pc_sel = (alu == 0); end
      6'b010001: begin e.cpi = 3; e.func = 4'b0001; e.b_sel = 1'b1; e.pc_sel = (alu != 0); end
      default:   begin e.cpi = 3; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  function automatic logic [11:0] observed();
    return {PC_Sel, PC_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel, ALU_Bin_sel,
            ALU_func, Mem_WrEn, Illegal_Instr};
  endfunction

  // Entered just after a rising edge with the FSM in FETCH; leaves the same way.
  task automatic run_instr(input logic [31:0] instr, input logic [31:0] alu, input string name);
    expect_t     e;
    logic        last;
    logic [11:0] exp_vec;
    logic [11:0] obs_vec;
    e = predict(instr, alu);
    Instr   = instr;
    ALU_Out = alu;
    for (int k = 1; k <= e.cpi; k++) begin
      @(negedge Clk);
      last    = (k == e.cpi);
      exp_vec = {last & e.pc_sel, last, last & e.rf_wr, e.wd_sel, e.b_sel, e.bin_sel,
                 e.func, last & e.mem_wr, last & e.ill};
      obs_vec = observed();
      test_count++;
      if (obs_vec !== exp_vec) begin
        fail_count++;
        $display("[TB] FAIL %s cycle %0d instr=%h alu=%h: got %b expected %b",
                 name, k, instr, alu, obs_vec, exp_vec);
      end
      @(posedge Clk);
      #1;
    end
    model_retired = model_retired + 32'd1;
    test_count++;
    if (Instr_Retired !== model_retired) begin
      fail_count++;
      $display("[TB] FAIL %s retired: got %h expected %h", name, Instr_Retired, model_retired);
    end
  endtask

  task automatic test_reset();
    Reset   = 1'b1;
    Instr   = {6'b100000, 22'h2A5A5, 4'b1111};
    ALU_Out = 32'd0;
    @(posedge Clk);
    @(negedge Clk);
    test_count++;
    if (observed() !== 12'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_outputs: got %b expected %b", observed(), 12'b0);
    end
    test_count++;
    if (Instr_Retired !== 32'd0) begin
      fail_count++;
      $display("[TB] FAIL reset_counter: got %h expected %h", Instr_Retired, 32'd0);
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    model_retired = 32'd0;
  endtask

  task automatic test_rtype();
    run_instr({6'b100000, 22'($urandom), 4'b0011}, $urandom, "rtype_or");
  endtask

  task automatic test_mem();
    run_instr({6'b000011, 26'($urandom)}, $urandom, "lw");
    run_instr({6'b011111, 26'($urandom)}, $urandom, "sw");
  endtask

  task automatic test_branch();
    run_instr({6'b010000, 26'($urandom)}, 32'd0, "beq_taken");
    run_instr({6'b010000, 26'($urandom)}, 32'd5, "beq_not_taken");
    run_instr({6'b010001, 26'($urandom)}, 32'd5, "bne_taken");
    run_instr({6'b010001, 26'($urandom)}, 32'd0, "bne_not_taken");
    run_instr({6'b111111, 26'($urandom)}, $urandom, "b_uncond");
  endtask

  task automatic test_illegal();
    run_instr({6'b000001, 26'($urandom)}, $urandom, "illegal");
  endtask

  task automatic test_reset_mid_lw();
    logic [11:0] exp_vec;
    Instr   = {6'b000011, 26'($urandom)};
    ALU_Out = $urandom;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    exp_vec = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    test_count++;
    if (observed() !== exp_vec) begin
      fail_count++;
      $display("[TB] FAIL mid_lw_mem_rd: got %b expected %b", observed(), exp_vec);
    end
    #2 Reset = 1'b1;
    #1;
    test_count++;
    if (observed() !== 12'b0) begin
      fail_count++;
      $display("[TB] FAIL async_reset_outputs: got %b expected %b", observed(), 12'b0);
    end
    test_count++;
    if (Instr_Retired !== 32'd0) begin
      fail_count++;
      $display("[TB] FAIL async_reset_counter: got %h expected %h", Instr_Retired, 32'd0);
    end
    @(posedge Clk);
    #1;
    test_count++;
    if (RF_WrEn !== 1'b0) begin
      fail_count++;
      $display("[TB] FAIL reset_no_write: got %b expected %b", RF_WrEn, 1'b0);
    end
    Reset = 1'b0;
    model_retired = 32'd0;
    run_instr({6'b110000, 26'($urandom)}, $urandom, "after_reset_addi");
  endtask

  task automatic test_wrap();
    force dut.instr_retired_q = 32'hFFFF_FFFF;
    #1 release dut.instr_retired_q;
    model_retired = 32'hFFFF_FFFF;
    run_instr({6'b111111, 26'($urandom)}, $urandom, "counter_wrap");
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr;
    logic [5:0]  op;
    logic [31:0] alu;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else begin
        op = LEGAL_OPS[$urandom_range(0, 8)];
      end
      instr = {op, 26'($urandom)};
      alu   = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
      run_instr(instr, alu, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_mem();
    test_branch();
    test_illegal();
    test_reset_mid_lw();
    test_wrap();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
